// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM with stall-aware memory handshake and traps.
// Optional JAL support is enabled by defining MCCTRL_JAL_EN.
module multicycle_control #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_write,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       result_src,
   output logic [1:0]       imm_src,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             illegal,
   output logic             timeout
);

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECR    = 4'd6;
   localparam logic [3:0] EXECI    = 4'd7;
   localparam logic [3:0] ALUWB    = 4'd8;
   localparam logic [3:0] BRANCH   = 4'd9;
`ifdef MCCTRL_JAL_EN
   localparam logic [3:0] JAL      = 4'd10;
`endif
   localparam logic [3:0] TRAP     = 4'd11;

   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] WLAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [3:0]    state, nxt;
   logic          run;
   logic [WW-1:0] wcnt;
   logic          req_r, mw_r, irw_r, pcw_r, rw_r, ret_r;
   logic          hs, waiting, set_ill, set_to;

   assign hs      = run & mem_ready;
   assign waiting = run & req_r & ~mem_ready;

   always_comb begin
      nxt        = state;
      set_ill    = 1'b0;
      set_to     = 1'b0;
      req_r      = 1'b0;
      mw_r       = 1'b0;
      irw_r      = 1'b0;
      pcw_r      = 1'b0;
      rw_r       = 1'b0;
      ret_r      = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      unique case (state)
         FETCH: begin
            req_r      = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (hs) begin
               irw_r = 1'b1;
               pcw_r = 1'b1;
               nxt   = DECODE;
            end
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op)
               7'b0000011,
               7'b0100011: nxt = MEMADR;
               7'b0110011: nxt = EXECR;
               7'b0010011: nxt = EXECI;
               7'b1100011: nxt = BRANCH;
`ifdef MCCTRL_JAL_EN
               7'b1101111: nxt = JAL;
`endif
               default: begin
                  nxt     = TRAP;
                  set_ill = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            nxt       = op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            req_r   = 1'b1;
            adr_src = 1'b1;
            if (hs) nxt = MEMWB;
         end
         MEMWB: begin
            result_src = 2'b01;
            rw_r       = 1'b1;
            ret_r      = 1'b1;
            nxt        = FETCH;
         end
         MEMWRITE: begin
            req_r   = 1'b1;
            mw_r    = 1'b1;
            adr_src = 1'b1;
            if (hs) begin
               ret_r = 1'b1;
               nxt   = FETCH;
            end
         end
         EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            nxt       = ALUWB;
         end
         EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            nxt       = ALUWB;
         end
         ALUWB: begin
            rw_r  = 1'b1;
            ret_r = 1'b1;
            nxt   = FETCH;
         end
         BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            case (funct3)
               3'b000: begin
                  pcw_r = zero;
                  ret_r = 1'b1;
                  nxt   = FETCH;
               end
               3'b001: begin
                  pcw_r = ~zero;
                  ret_r = 1'b1;
                  nxt   = FETCH;
               end
               default: begin
                  nxt     = TRAP;
                  set_ill = 1'b1;
               end
            endcase
         end
`ifdef MCCTRL_JAL_EN
         JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pcw_r     = 1'b1;
            nxt       = ALUWB;
         end
`endif
         TRAP: nxt = TRAP;
         default: nxt = FETCH;
      endcase
      // trap on the edge where the wait count reaches TIMEOUT
      if ((TIMEOUT != 0) && waiting && (wcnt == WLAST)) begin
         nxt    = TRAP;
         set_to = 1'b1;
      end
   end

   always_comb begin
      case (op)
         7'b0100011: imm_src = 2'b01;
         7'b1100011: imm_src = 2'b10;
         7'b1101111: imm_src = 2'b11;
         default:    imm_src = 2'b00;
      endcase
   end

   assign mem_req   = run & req_r;
   assign mem_write = run & mw_r;
   assign ir_write  = run & irw_r;
   assign pc_write  = run & pcw_r;
   assign reg_write = run & rw_r;
   assign retire    = run & ret_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH;
         run     <= 1'b0;
         wcnt    <= '0;
         instret <= '0;
         illegal <= 1'b0;
         timeout <= 1'b0;
      end else begin
         run   <= 1'b1;
         state <= nxt;
         if (mem_req && mem_ready) wcnt <= '0;
         else if (mem_req)         wcnt <= wcnt + 1'b1;
         if (retire)  instret <= instret + 1'b1;
         if (set_ill) illegal <= 1'b1;
         if (set_to)  timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control (CNT_W=4, TIMEOUT=15).
// Multi-cycle corner cases (traps, timeout, counter wrap) are hand-written.
module tb_multicycle_control;

   logic       clk, rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       zero, mem_ready;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
   logic       retire, illegal, timeout;
   logic [3:0] instret;

   multicycle_control #(.CNT_W(4), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
      .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
      .retire(retire), .instret(instret), .illegal(illegal),
      .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic       z;
      int         ws;
      int         wn;
      logic       wadr;
      int         lat;
      logic       pcw;
      logic       rw;
      logic       mw;
      logic [1:0] imm;
   } vec_t;

   int nchk = 0;
   int nfail = 0;
   logic [3:0] exp_cnt;

   task automatic chk(input string n, input longint a, input longint e);
      nchk++;
      if (a != e) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   task automatic run_instr(input vec_t t, output int cyc, output logic pcw,
                            output logic rw, output logic mw,
                            output logic [1:0] im, output int held,
                            output int badadr, output bit got);
      op = t.op; funct3 = t.f3; zero = t.z;
      cyc = 0; got = 0; held = 0; badadr = 0;
      pcw = 0; rw = 0; mw = 0; im = 2'b00;
      while (!got && cyc < 40) begin
         cyc++;
         mem_ready = !(t.wn > 0 && cyc >= t.ws && cyc < t.ws + t.wn);
         #1;
         if (cyc == 2) im = imm_src;
         if (!mem_ready) begin
            if (mem_req) held++;
            if (adr_src != t.wadr) badadr++;
         end
         if (retire) begin
            got = 1; pcw = pc_write; rw = reg_write; mw = mem_write;
         end
         @(negedge clk);
      end
      mem_ready = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_illegal", illegal, 0);
      chk("rst_instret", instret, 0);
      chk("rst_mem_req", mem_req, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("restart_fetch_req", mem_req, 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_cnt = 4'd0;
   endtask

   task automatic trap_seq(input string n, input logic [6:0] o,
                           input logic [2:0] f);
      int nreq, nret;
      op = o; funct3 = f; zero = 1'b0; mem_ready = 1'b1;
      nreq = 0; nret = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (i >= 3 && mem_req) nreq++;
         if (retire) nret++;
         @(negedge clk);
      end
      chk({n, "_illegal"}, illegal, 1);
      chk({n, "_req_after"}, nreq, 0);
      chk({n, "_no_retire"}, nret, 0);
      chk({n, "_instret"}, instret, exp_cnt);
   endtask

   vec_t v[11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, held, badadr, n;
      logic pcw, rw, mw;
      logic [1:0] im;
      bit got;

      v[0]  = '{"add",    7'b0110011, 3'd0, 1'b0, 0, 0, 1'b0, 4, 1'b0, 1'b1, 1'b0, 2'b00};
      v[1]  = '{"addi",   7'b0010011, 3'd0, 1'b0, 0, 0, 1'b0, 4, 1'b0, 1'b1, 1'b0, 2'b00};
      v[2]  = '{"lw",     7'b0000011, 3'd2, 1'b0, 0, 0, 1'b0, 5, 1'b0, 1'b1, 1'b0, 2'b00};
      v[3]  = '{"sw",     7'b0100011, 3'd2, 1'b0, 0, 0, 1'b0, 4, 1'b0, 1'b0, 1'b1, 2'b01};
      v[4]  = '{"beq_t",  7'b1100011, 3'd0, 1'b1, 0, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 2'b10};
      v[5]  = '{"beq_n",  7'b1100011, 3'd0, 1'b0, 0, 0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 2'b10};
      v[6]  = '{"bne_n",  7'b1100011, 3'd1, 1'b1, 0, 0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 2'b10};
      v[7]  = '{"bne_t",  7'b1100011, 3'd1, 1'b0, 0, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 2'b10};
      v[8]  = '{"add_fw", 7'b0110011, 3'd0, 1'b0, 1, 2, 1'b0, 6, 1'b0, 1'b1, 1'b0, 2'b00};
      v[9]  = '{"lw_mw",  7'b0000011, 3'd2, 1'b0, 4, 3, 1'b1, 8, 1'b0, 1'b1, 1'b0, 2'b00};
      v[10] = '{"sw_mw",  7'b0100011, 3'd2, 1'b0, 4, 1, 1'b1, 5, 1'b0, 1'b0, 1'b1, 2'b01};

      rst_n = 1'b0; mem_ready = 1'b1;
      op = 7'b0110011; funct3 = 3'd0; zero = 1'b0;
      exp_cnt = 4'd0;
      #12;
      chk("reset_mem_req", mem_req, 0);
      chk("reset_instret", instret, 0);
      chk("reset_illegal", illegal, 0);
      chk("reset_timeout", timeout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("run_gate_req", mem_req, 0);
      chk("run_gate_irw", ir_write, 0);
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         run_instr(v[i], cyc, pcw, rw, mw, im, held, badadr, got);
         chk({v[i].name, "_retired"}, got, 1);
         chk({v[i].name, "_latency"}, cyc, v[i].lat);
         chk({v[i].name, "_pc_write"}, pcw, v[i].pcw);
         chk({v[i].name, "_reg_write"}, rw, v[i].rw);
         chk({v[i].name, "_mem_write"}, mw, v[i].mw);
         chk({v[i].name, "_imm_src"}, im, v[i].imm);
         if (got) exp_cnt = exp_cnt + 4'd1;
         chk({v[i].name, "_instret"}, instret, exp_cnt);
         if (v[i].wn > 0) begin
            chk({v[i].name, "_req_held"}, held, v[i].wn);
            chk({v[i].name, "_adr_held"}, badadr, 0);
         end
      end

      trap_seq("illegal_op", 7'b1111111, 3'd0);
      do_reset();
      trap_seq("bad_branch", 7'b1100011, 3'd4);
      do_reset();
`ifdef MCCTRL_JAL_EN
      begin
         vec_t j;
         j = '{"jal", 7'b1101111, 3'd0, 1'b0, 0, 0, 1'b0, 4, 1'b0, 1'b1, 1'b0, 2'b11};
         run_instr(j, cyc, pcw, rw, mw, im, held, badadr, got);
         chk("jal_latency", cyc, j.lat);
         chk("jal_reg_write", rw, 1);
         chk("jal_no_illegal", illegal, 0);
      end
      do_reset();
`else
      trap_seq("jal_disabled", 7'b1101111, 3'd0);
      do_reset();
`endif

      mem_ready = 1'b0;
      op = 7'b0110011;
      n = 0;
      while (!timeout && n < 40) begin
         #1;
         if (mem_req) n++;
         @(negedge clk);
      end
      #1;
      chk("timeout_wait_cycles", n, 15);
      chk("timeout_flag", timeout, 1);
      chk("timeout_req_drop", mem_req, 0);
      chk("timeout_not_illegal", illegal, 0);
      mem_ready = 1'b1;
      do_reset();

      for (int i = 0; i < 16; i++) begin
         run_instr(v[0], cyc, pcw, rw, mw, im, held, badadr, got);
         if (got) exp_cnt = exp_cnt + 4'd1;
         if (i == 14) chk("instret_15", instret, 15);
      end
      chk("instret_wrap", instret, 0);
      chk("instret_wrap_model", instret, exp_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
